// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the memory responder: the data word, the responder FSM
// state encoding, the LL/SC link register layout and a word-address helper.
// ---------------------------------------------------------------------------
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2,
    DONE = 2'd3
  } memstate_t;

  typedef struct packed {
    logic        valid;
    logic [29:0] addr;
  } link_t;

  // Rebuild a RAM byte address from a 30-bit word address.
  function automatic word_t ram_word_addr(input logic [29:0] waddr);
    return {waddr, 2'b00};
  endfunction

endpackage

// File: rtl/mem_responder_llsc_link.sv
// ---------------------------------------------------------------------------
// llsc_link
// LL/SC link register: valid bit plus 30-bit word address. Set when an LL
// read completes, cleared by any completed local write to the linked word
// (this covers a successful SC) and by a matching snoop from the other core.
// A snoop beats a same-cycle LL set to the same word.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_set            LL read completes this cycle
//   i_wr             local write completes this cycle
//   i_acc_addr       word address of the completing access
//   i_snoop_valid    other core committed a store this cycle
//   i_snoop_addr     byte address of that store
//   i_chk_addr       word address of the SC being evaluated
//   o_match          link valid and equal to i_chk_addr
// ---------------------------------------------------------------------------
module llsc_link
  import cpu_types_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_set,
  input  logic        i_wr,
  input  logic [29:0] i_acc_addr,
  input  logic        i_snoop_valid,
  input  word_t       i_snoop_addr,
  input  logic [29:0] i_chk_addr,
  output logic        o_match
);

  link_t r_link;
  link_t w_link_next;
  logic  w_unused;

  assign w_unused = ^i_snoop_addr[1:0];
  assign o_match  = r_link.valid && (r_link.addr == i_chk_addr);

  // Link update: set first, then local-write clear, then snoop clear so the
  // snoop has the final say.
  always_comb begin
    w_link_next = r_link;
    if (i_set) begin
      w_link_next.valid = 1'b1;
      w_link_next.addr  = i_acc_addr;
    end else if (i_wr && (i_acc_addr == r_link.addr)) begin
      w_link_next.valid = 1'b0;
    end else begin
      w_link_next = r_link;
    end
    if (i_snoop_valid && (i_snoop_addr[31:2] == w_link_next.addr)) begin
      w_link_next.valid = 1'b0;
    end else begin
      w_link_next.valid = w_link_next.valid;
    end
  end

  // Link register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_link <= '{valid: 1'b0, addr: 30'd0};
    end else begin
      r_link <= w_link_next;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Memory-side responder for one core: arbitrates instruction fetch and data
// requests onto one single-ported, variable-latency RAM port (data beats
// fetch) and returns one-cycle ihit/dhit pulses with the load data.
//
// Optional feature macro: LLSC_EN enables the LL/SC link register (llsc_link)
// and snoop-based link breaking. Without it, llsc and the snoop inputs are
// ignored and LL/SC behave as plain read/write.
//
// Ports:
//   CLK, nRST                      clock, asynchronous active-low reset
//   imemREN, imemaddr              fetch request (held until ihit)
//   dmemREN, dmemWEN, dmemaddr,
//   dmemstore, llsc                data request (held until dhit)
//   snoop_valid, snoop_addr        other core's committed store
//   ihit, imemload                 fetch completion pulse and instruction
//   dhit, dmemload                 data completion pulse and load/SC result
//   ram_ren, ram_wen, ram_addr,
//   ram_store, ram_load, ram_ready RAM port
// ---------------------------------------------------------------------------
module mem_responder
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  input  logic  dmemREN,
  input  logic  dmemWEN,
  input  word_t dmemaddr,
  input  word_t dmemstore,
  input  logic  llsc,
  input  logic  snoop_valid,
  input  word_t snoop_addr,
  output logic  ihit,
  output logic  dhit,
  output word_t imemload,
  output word_t dmemload,
  output logic  ram_ren,
  output logic  ram_wen,
  output word_t ram_addr,
  output word_t ram_store,
  input  word_t ram_load,
  input  logic  ram_ready
);

  memstate_t   r_state, w_state_next;
  logic [29:0] r_waddr, w_waddr_next;
  word_t       r_store, w_store_next;
  word_t       r_result, w_result_next;
  logic        r_is_write, w_is_write_next;
  logic        r_is_data, w_is_data_next;
  logic        r_is_sc, w_is_sc_next;
  logic        r_is_ll, w_is_ll_next;
  logic        r_ihit, w_ihit_next;
  logic        r_dhit, w_dhit_next;
  logic        r_ram_ren, w_ram_ren_next;
  logic        r_ram_wen, w_ram_wen_next;

  logic        w_llsc;
  logic        w_sc_ok;
  logic        w_unused;

`ifdef LLSC_EN
  logic w_ll_set;
  logic w_wr_done;

  assign w_llsc    = llsc;
  assign w_ll_set  = (r_state == DACC) && ram_ready && r_is_ll;
  assign w_wr_done = (r_state == DACC) && ram_ready && r_is_write;
  assign w_unused  = ^{imemaddr[1:0], dmemaddr[1:0]};

  llsc_link u_link (
    .i_clk         (CLK),
    .i_rst_n       (nRST),
    .i_set         (w_ll_set),
    .i_wr          (w_wr_done),
    .i_acc_addr    (r_waddr),
    .i_snoop_valid (snoop_valid),
    .i_snoop_addr  (snoop_addr),
    .i_chk_addr    (dmemaddr[31:2]),
    .o_match       (w_sc_ok)
  );
`else
  // Without the link register every SC is a plain write, so w_sc_ok is moot.
  assign w_llsc   = 1'b0;
  assign w_sc_ok  = 1'b1;
  assign w_unused = ^{llsc, snoop_valid, snoop_addr, imemaddr[1:0],
                      dmemaddr[1:0], r_is_ll};
`endif

  assign ihit      = r_ihit;
  assign dhit      = r_dhit;
  assign imemload  = r_result;
  assign dmemload  = r_result;
  assign ram_ren   = r_ram_ren;
  assign ram_wen   = r_ram_wen;
  assign ram_addr  = ram_word_addr(r_waddr);
  assign ram_store = r_store;

  // Next-state and next-output logic; strobes are registered, so they are
  // computed here one cycle ahead of the state they belong to.
  always_comb begin
    w_state_next    = r_state;
    w_waddr_next    = r_waddr;
    w_store_next    = r_store;
    w_result_next   = r_result;
    w_is_write_next = r_is_write;
    w_is_data_next  = r_is_data;
    w_is_sc_next    = r_is_sc;
    w_is_ll_next    = r_is_ll;
    w_ihit_next     = 1'b0;
    w_dhit_next     = 1'b0;
    w_ram_ren_next  = r_ram_ren;
    w_ram_wen_next  = r_ram_wen;
    case (r_state)
      IDLE: begin
        w_ram_ren_next = 1'b0;
        w_ram_wen_next = 1'b0;
        if (dmemREN || dmemWEN) begin
          w_waddr_next    = dmemaddr[31:2];
          w_store_next    = dmemstore;
          w_is_write_next = dmemWEN;
          w_is_data_next  = 1'b1;
          w_is_sc_next    = w_llsc && dmemWEN;
          w_is_ll_next    = w_llsc && !dmemWEN;
          if (w_llsc && dmemWEN && !w_sc_ok) begin
            // Failed SC: answer immediately without touching the RAM.
            w_state_next  = DONE;
            w_dhit_next   = 1'b1;
            w_result_next = 32'd0;
          end else begin
            w_state_next   = DACC;
            w_ram_ren_next = !dmemWEN;
            w_ram_wen_next = dmemWEN;
          end
        end else if (imemREN) begin
          w_waddr_next    = imemaddr[31:2];
          w_is_write_next = 1'b0;
          w_is_data_next  = 1'b0;
          w_is_sc_next    = 1'b0;
          w_is_ll_next    = 1'b0;
          w_state_next    = IACC;
          w_ram_ren_next  = 1'b1;
        end else begin
          w_state_next = IDLE;
        end
      end
      IACC, DACC: begin
        if (ram_ready) begin
          w_result_next  = r_is_write ? {31'd0, r_is_sc} : ram_load;
          w_ram_ren_next = 1'b0;
          w_ram_wen_next = 1'b0;
          w_ihit_next    = !r_is_data;
          w_dhit_next    = r_is_data;
          w_state_next   = DONE;
        end else begin
          w_state_next = r_state;
        end
      end
      DONE: begin
        w_ram_ren_next = 1'b0;
        w_ram_wen_next = 1'b0;
        w_state_next   = IDLE;
      end
      default: begin
        w_ram_ren_next = 1'b0;
        w_ram_wen_next = 1'b0;
        w_state_next   = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Latched request, result and registered outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_waddr    <= 30'd0;
      r_store    <= 32'd0;
      r_result   <= 32'd0;
      r_is_write <= 1'b0;
      r_is_data  <= 1'b0;
      r_is_sc    <= 1'b0;
      r_is_ll    <= 1'b0;
      r_ihit     <= 1'b0;
      r_dhit     <= 1'b0;
      r_ram_ren  <= 1'b0;
      r_ram_wen  <= 1'b0;
    end else begin
      r_waddr    <= w_waddr_next;
      r_store    <= w_store_next;
      r_result   <= w_result_next;
      r_is_write <= w_is_write_next;
      r_is_data  <= w_is_data_next;
      r_is_sc    <= w_is_sc_next;
      r_is_ll    <= w_is_ll_next;
      r_ihit     <= w_ihit_next;
      r_dhit     <= w_dhit_next;
      r_ram_ren  <= w_ram_ren_next;
      r_ram_wen  <= w_ram_wen_next;
    end
  end

endmodule
